// File: rtl/regaddr_pkg.sv
// regaddr_pkg: shared encodings, defaults and types for the register-address forwarding unit
package regaddr_pkg;
  localparam logic [1:0] RW_RT = 2'd0;
  localparam logic [1:0] RW_RD = 2'd1;
  localparam logic [1:0] RW_LINK = 2'd2;
  localparam int SYS_REG_DEF = 2;
  localparam int LINK_REG_DEF = 31;
  localparam int ENTRY_AW = 5;
  typedef struct packed {
    logic valid;
    logic is_load;
    logic [ENTRY_AW-1:0] rw;
  } stage_entry_t;
  function automatic int fw_width(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/fwd_match.sv
// fwd_match: priority compare of one read address against tracked stages 1..DEPTH-1
module fwd_match
  import regaddr_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int DEPTH = 3,
  parameter int FW = fw_width(DEPTH)
) (
  input  logic                    en,
  input  logic [REG_AW-1:0]       addr,
  input  logic [DEPTH-1:0]        valid,
  input  logic [DEPTH*REG_AW-1:0] rws,
  output logic [FW-1:0]           sel
);
  // scan oldest to youngest so the youngest match overwrites
  always_comb begin
    sel = '0;
    for (int k = DEPTH - 1; k >= 1; k--)
      if (en && addr != '0 && valid[k] && rws[k*REG_AW +: REG_AW] == addr) sel = FW'(k);
  end
endmodule

// File: rtl/regaddr_fwd_unit.sv
// regaddr_fwd_unit: ID register-address select, destination tracking, forwarding selects and load-use stall
module regaddr_fwd_unit
  import regaddr_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH = 3,
  parameter int SYS_REG = SYS_REG_DEF,
  parameter int LINK_REG = LINK_REG_DEF,
  parameter int FW = fw_width(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    hold,
  input  logic                    flush,
  input  logic                    id_valid,
  input  logic [1:0]              choose_rw,
  input  logic [REG_AW-1:0]       rs,
  input  logic [REG_AW-1:0]       rt,
  input  logic [REG_AW-1:0]       rd,
  input  logic [DATA_W-1:0]       ext5,
  input  logic [DATA_W-1:0]       ext16,
  input  logic                    extu,
  input  logic                    sys,
  input  logic                    uses_rb,
  input  logic                    reg_write,
  input  logic                    is_load,
  output logic [REG_AW-1:0]       ra,
  output logic [REG_AW-1:0]       rb,
  output logic [REG_AW-1:0]       rw,
  output logic [DATA_W-1:0]       ext_out,
  output logic [FW-1:0]           fwd_a,
  output logic [FW-1:0]           fwd_b,
  output logic                    load_use_stall,
  output logic [DEPTH-1:0]        stage_valid,
  output logic [DEPTH*REG_AW-1:0] stage_rw
);
  logic [DEPTH-1:0] st_load;
  logic [REG_AW-1:0] rw0;
  logic adv;
  always_comb begin
    ra = sys ? REG_AW'(SYS_REG) : (extu ? rt : rs);
    rb = rt;
    rw = choose_rw == RW_LINK ? REG_AW'(LINK_REG) : (choose_rw == RW_RD ? rd : rt);
    ext_out = extu ? ext5 : ext16;
    rw0 = stage_rw[REG_AW-1:0];
    load_use_stall = id_valid & ~flush & stage_valid[0] & st_load[0] &
                     (rw0 == ra | (uses_rb & rw0 == rb));
    adv = id_valid & ~flush & ~load_use_stall;
  end
  always_ff @(posedge clk)
    if (rst) begin
      stage_valid <= '0;
      st_load <= '0;
      stage_rw <= '0;
    end else if (!hold) begin
      stage_valid <= {stage_valid[DEPTH-2:0], adv & reg_write & (rw != '0)};
      st_load <= {st_load[DEPTH-2:0], adv & is_load};
      stage_rw <= {stage_rw[(DEPTH-1)*REG_AW-1:0], adv ? rw : REG_AW'(0)};
    end
  fwd_match #(.REG_AW(REG_AW), .DEPTH(DEPTH), .FW(FW)) u_fwd_a (
    .en(1'b1), .addr(ra), .valid(stage_valid), .rws(stage_rw), .sel(fwd_a)
  );
  fwd_match #(.REG_AW(REG_AW), .DEPTH(DEPTH), .FW(FW)) u_fwd_b (
    .en(uses_rb), .addr(rb), .valid(stage_valid), .rws(stage_rw), .sel(fwd_b)
  );
endmodule

// File: tb/tb_regaddr_fwd_unit.sv
// tb_regaddr_fwd_unit: scoreboard bench for regaddr_fwd_unit with an independent stage model
module tb_regaddr_fwd_unit;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int D = 3;
  localparam int FW = $clog2(D + 1);
  typedef struct {
    int ra, rb, rw, fa, fb, stall, sv, srw;
    logic [DW-1:0] ext;
  } exp_t;
  logic clk = 0, rst, hold, flush, id_valid, extu, sys, uses_rb, reg_write, is_load;
  logic [1:0] choose_rw;
  logic [AW-1:0] rs, rt, rd, ra, rb, rw;
  logic [DW-1:0] ext5, ext16, ext_out;
  logic [FW-1:0] fwd_a, fwd_b;
  logic load_use_stall;
  logic [D-1:0] stage_valid;
  logic [D*AW-1:0] stage_rw;
  int n_chk = 0, n_pass = 0;
  int m_v[D], m_l[D], m_rw[D];
  exp_t sb[$];
  always #5 clk = ~clk;
  regaddr_fwd_unit dut (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush), .id_valid(id_valid),
    .choose_rw(choose_rw), .rs(rs), .rt(rt), .rd(rd), .ext5(ext5), .ext16(ext16),
    .extu(extu), .sys(sys), .uses_rb(uses_rb), .reg_write(reg_write), .is_load(is_load),
    .ra(ra), .rb(rb), .rw(rw), .ext_out(ext_out), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .load_use_stall(load_use_stall), .stage_valid(stage_valid), .stage_rw(stage_rw)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask
  function automatic int fsel(input int a, input int en);
    for (int k = 1; k < D; k++)
      if (en != 0 && a != 0 && m_v[k] != 0 && m_rw[k] == a) return k;
    return 0;
  endfunction
  task automatic go(input bit r, h, f, iv, input bit [1:0] crw, input int s, t, d,
                    input bit ex, sy, ub, we, ld);
    exp_t e, o;
    int adv;
    rst = r; hold = h; flush = f; id_valid = iv; choose_rw = crw;
    rs = AW'(s); rt = AW'(t); rd = AW'(d); extu = ex; sys = sy;
    uses_rb = ub; reg_write = we; is_load = ld;
    ext5 = $urandom; ext16 = $urandom;
    e.ra = sy ? 2 : (ex ? t : s);
    e.rb = t;
    e.rw = crw == 2 ? 31 : (crw == 1 ? d : t);
    e.ext = ex ? ext5 : ext16;
    e.fa = fsel(e.ra, 1);
    e.fb = fsel(e.rb, ub);
    e.stall = (iv && !f && m_v[0] != 0 && m_l[0] != 0 &&
               (m_rw[0] == e.ra || (ub && m_rw[0] == e.rb))) ? 1 : 0;
    e.sv = 0; e.srw = 0;
    for (int k = 0; k < D; k++) begin
      e.sv |= m_v[k] << k;
      e.srw |= m_rw[k] << (k * AW);
    end
    sb.push_back(e);
    @(negedge clk);
    o = sb.pop_front();
    chk("ra", ra, o.ra); chk("rb", rb, o.rb); chk("rw", rw, o.rw);
    chk("ext_out", ext_out, o.ext); chk("fwd_a", fwd_a, o.fa); chk("fwd_b", fwd_b, o.fb);
    chk("stall", load_use_stall, o.stall); chk("stage_valid", stage_valid, o.sv);
    chk("stage_rw", stage_rw, o.srw);
    @(posedge clk);
    if (r) begin
      for (int k = 0; k < D; k++) begin m_v[k] = 0; m_l[k] = 0; m_rw[k] = 0; end
    end else if (!h) begin
      for (int k = D - 1; k > 0; k--) begin
        m_v[k] = m_v[k-1]; m_l[k] = m_l[k-1]; m_rw[k] = m_rw[k-1];
      end
      adv = (iv && !f && o.stall == 0) ? 1 : 0;
      m_v[0] = (adv != 0 && we && o.rw != 0) ? 1 : 0;
      m_l[0] = (adv != 0 && ld) ? 1 : 0;
      m_rw[0] = adv != 0 ? o.rw : 0;
    end
    #1;
  endtask
  initial begin
    for (int k = 0; k < D; k++) begin m_v[k] = 0; m_l[k] = 0; m_rw[k] = 0; end
    @(posedge clk); #1;
    go(1,0,0,0, 0, 0,0,0, 0,0,0,0,0);
    go(1,0,0,0, 0, 0,0,0, 0,0,0,0,0);
    go(0,0,0,0, 0, 5,7,0, 1,1,0,0,0);
    go(0,0,0,0, 0, 5,7,0, 1,0,0,0,0);
    go(0,0,0,0, 2, 5,7,0, 0,0,0,0,0);
    go(0,0,0,0, 1, 5,7,9, 0,0,0,0,0);
    go(0,0,0,1, 1, 1,2,8, 0,0,1,1,0);
    go(0,0,0,1, 0, 8,3,0, 0,0,1,0,0);
    go(0,0,0,1, 0, 8,3,0, 0,0,1,0,0);
    go(0,0,0,1, 0, 8,3,0, 0,0,1,0,0);
    go(0,0,0,1, 1, 1,2,8, 0,0,1,1,0);
    go(0,0,0,1, 1, 1,2,8, 0,0,1,1,0);
    go(0,0,0,0, 0, 0,0,0, 0,0,0,0,0);
    go(0,0,0,1, 0, 8,3,0, 0,0,1,0,0);
    go(0,0,0,1, 0, 1,4,0, 0,0,0,1,1);
    go(0,0,0,1, 0, 6,4,0, 0,0,1,1,0);
    go(0,0,0,1, 0, 6,4,0, 0,0,1,1,0);
    go(0,0,0,1, 0, 6,4,0, 0,0,1,1,0);
    go(0,0,0,1, 1, 1,2,0, 0,0,1,1,0);
    go(0,0,0,1, 0, 1,0,0, 0,0,0,1,1);
    go(0,0,0,1, 0, 0,0,0, 0,0,1,0,0);
    go(0,0,0,1, 0, 0,0,0, 0,0,1,0,0);
    go(0,0,0,1, 1, 1,2,12, 0,0,1,1,0);
    go(0,1,1,1, 1, 1,2,13, 0,0,1,1,0);
    go(0,1,1,1, 1, 1,2,13, 0,0,1,1,0);
    go(0,1,1,1, 1, 1,2,13, 0,0,1,1,0);
    go(0,0,1,1, 1, 1,2,13, 0,0,1,1,0);
    go(0,0,0,1, 0, 1,4,0, 0,0,0,1,1);
    go(1,1,0,1, 0, 6,4,0, 0,0,1,0,0);
    go(0,0,0,1, 0, 6,4,0, 0,0,1,0,0);
    for (int i = 0; i < 300; i++)
      go($urandom_range(0, 40) == 0, $urandom_range(0, 6) == 0, $urandom_range(0, 6) == 0,
         $urandom_range(0, 5) != 0, 2'($urandom_range(0, 3)),
         $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5),
         $urandom_range(0, 4) == 0, $urandom_range(0, 8) == 0, $urandom_range(0, 1) == 1,
         $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
